// File: rtl/uart_fifo_core.sv
// uart_fifo_core: UART with a shared oversample tick generator, a 16x-oversampled
// receiver with start-bit glitch rejection, a transmitter, one first-word-fall-through
// FIFO per direction and sticky parity/framing/overrun flags.
module uart_fifo_core #(
  parameter int unsigned DBIT      = 8,
  parameter int unsigned PAR_EN    = 0,
  parameter int unsigned PAR_ODD   = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned DIVISOR   = 326,
  parameter int unsigned FIFO_W    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  output logic            tx,
  input  logic            wr,
  input  logic [DBIT-1:0] w_data,
  input  logic            rd,
  output logic [DBIT-1:0] r_data,
  output logic            rx_empty,
  output logic            tx_full,
  output logic            tx_busy,
  input  logic            err_clr,
  output logic            parity_err,
  output logic            frame_err,
  output logic            overrun_err
);

  localparam int unsigned Depth = 2 ** FIFO_W;
  localparam int unsigned DivW  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  localparam logic [DivW-1:0]   DivLast  = DivW'(DIVISOR - 1);
  localparam logic [DivW-1:0]   DivOne   = DivW'(1);
  localparam logic [FIFO_W-1:0] PtrOne   = FIFO_W'(1);
  localparam logic [FIFO_W:0]   CntOne   = {{FIFO_W{1'b0}}, 1'b1};
  localparam logic [FIFO_W:0]   CntFull  = {1'b1, {FIFO_W{1'b0}}};
  localparam logic [5:0]        StopLast = 6'(16 * STOP_BITS - 1);
  localparam logic [3:0]        BitLast  = 4'(DBIT - 1);
  localparam logic              ParOdd   = (PAR_ODD != 0);

  // Shared by both FSMs
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StPar   = 3'd3;
  localparam logic [2:0] StStop  = 3'd4;

  localparam logic [2:0] StAfterData = (PAR_EN != 0) ? StPar : StStop;

  // --------------------------------------------------------------------------
  // Oversample tick
  // --------------------------------------------------------------------------
  logic [DivW-1:0] div_q;
  logic            tick;

  assign tick = (div_q == DivLast);

  // Free-running divider; tick marks its last count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DivOne;
    end
  end

  // --------------------------------------------------------------------------
  // RX synchroniser and FSM
  // --------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q;

  // Two-flop synchroniser; resets to the idle line level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  logic [2:0]      rx_state_q, rx_state_d;
  logic [5:0]      rx_tick_q, rx_tick_d;
  logic [3:0]      rx_bit_q, rx_bit_d;
  logic [DBIT-1:0] rx_shift_q, rx_shift_d;
  logic            rx_push, par_set, frame_set;

  // Receiver next state: centre-of-bit sampling on oversample ticks
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    par_set    = 1'b0;
    frame_set  = 1'b0;
    case (rx_state_q)
      StIdle: begin
        if (!rx_sync_q) begin
          rx_tick_d  = '0;
          rx_state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          if (rx_tick_q == 6'd7) begin
            // Mid start bit: a line already back high was only a glitch
            rx_tick_d  = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_sync_q ? StIdle : StData;
          end else begin
            rx_tick_d = rx_tick_q + 6'd1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (rx_tick_q == 6'd15) begin
            rx_tick_d  = '0;
            rx_shift_d = {rx_sync_q, rx_shift_q[DBIT-1:1]};
            if (rx_bit_q == BitLast) begin
              rx_state_d = StAfterData;
            end else begin
              rx_bit_d = rx_bit_q + 4'd1;
            end
          end else begin
            rx_tick_d = rx_tick_q + 6'd1;
          end
        end
      end
      StPar: begin
        if (tick) begin
          if (rx_tick_q == 6'd15) begin
            rx_tick_d  = '0;
            par_set    = (rx_sync_q != (^rx_shift_q ^ ParOdd));
            rx_state_d = StStop;
          end else begin
            rx_tick_d = rx_tick_q + 6'd1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (rx_tick_q == StopLast) begin
            // Word is delivered even when framing or parity failed
            rx_tick_d  = '0;
            frame_set  = !rx_sync_q;
            rx_push    = 1'b1;
            rx_state_d = StIdle;
          end else begin
            rx_tick_d = rx_tick_q + 6'd1;
          end
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  // Receiver state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q <= StIdle;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // --------------------------------------------------------------------------
  // RX FIFO
  // --------------------------------------------------------------------------
  logic [DBIT-1:0]   rx_mem [Depth];
  logic [FIFO_W-1:0] rx_wptr_q, rx_rptr_q;
  logic [FIFO_W:0]   rx_cnt_q;
  logic              rx_full, rx_pop, rx_wr_en, ovr_set;

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CntFull);
  assign rx_pop   = rd && !rx_empty;
  // A pop in the same cycle frees the slot for the incoming word
  assign rx_wr_en = rx_push && (!rx_full || rx_pop);
  assign ovr_set  = rx_push && rx_full && !rx_pop;
  assign r_data   = rx_empty ? '0 : rx_mem[rx_rptr_q];

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (rx_wr_en) rx_wptr_q <= rx_wptr_q + PtrOne;
      if (rx_pop)   rx_rptr_q <= rx_rptr_q + PtrOne;
      if (rx_wr_en && !rx_pop) begin
        rx_cnt_q <= rx_cnt_q + CntOne;
      end else if (!rx_wr_en && rx_pop) begin
        rx_cnt_q <= rx_cnt_q - CntOne;
      end
    end
  end

  // --------------------------------------------------------------------------
  // TX FIFO
  // --------------------------------------------------------------------------
  logic [DBIT-1:0]   tx_mem [Depth];
  logic [FIFO_W-1:0] tx_wptr_q, tx_rptr_q;
  logic [FIFO_W:0]   tx_cnt_q;
  logic              tx_empty, tx_wr_en, tx_pop;
  logic [DBIT-1:0]   tx_head;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == CntFull);
  assign tx_wr_en = wr && !tx_full;
  assign tx_head  = tx_mem[tx_rptr_q];

  // TX FIFO pointers and occupancy; pops only come from a non-empty FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
    end else begin
      if (tx_wr_en) tx_wptr_q <= tx_wptr_q + PtrOne;
      if (tx_pop)   tx_rptr_q <= tx_rptr_q + PtrOne;
      if (tx_wr_en && !tx_pop) begin
        tx_cnt_q <= tx_cnt_q + CntOne;
      end else if (!tx_wr_en && tx_pop) begin
        tx_cnt_q <= tx_cnt_q - CntOne;
      end
    end
  end

  // FIFO storage; pointers and counts carry the reset
  always_ff @(posedge clk) begin
    if (rx_wr_en) rx_mem[rx_wptr_q] <= rx_shift_q;
    if (tx_wr_en) tx_mem[tx_wptr_q] <= w_data;
  end

  // --------------------------------------------------------------------------
  // TX FSM
  // --------------------------------------------------------------------------
  logic [2:0]      tx_state_q, tx_state_d;
  logic [5:0]      tx_tick_q, tx_tick_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [DBIT-1:0] tx_shift_q, tx_shift_d;
  logic            tx_par_q, tx_par_d;

  // Transmitter next state; the last stop tick chains straight into the next frame
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      StIdle: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_par_d   = ^tx_head ^ ParOdd;
          tx_tick_d  = '0;
          tx_state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          if (tx_tick_q == 6'd15) begin
            tx_tick_d  = '0;
            tx_bit_d   = '0;
            tx_state_d = StData;
          end else begin
            tx_tick_d = tx_tick_q + 6'd1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (tx_tick_q == 6'd15) begin
            tx_tick_d  = '0;
            tx_shift_d = tx_shift_q >> 1;
            if (tx_bit_q == BitLast) begin
              tx_state_d = StAfterData;
            end else begin
              tx_bit_d = tx_bit_q + 4'd1;
            end
          end else begin
            tx_tick_d = tx_tick_q + 6'd1;
          end
        end
      end
      StPar: begin
        if (tick) begin
          if (tx_tick_q == 6'd15) begin
            tx_tick_d  = '0;
            tx_state_d = StStop;
          end else begin
            tx_tick_d = tx_tick_q + 6'd1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (tx_tick_q == StopLast) begin
            tx_tick_d = '0;
            if (!tx_empty) begin
              tx_pop     = 1'b1;
              tx_shift_d = tx_head;
              tx_par_d   = ^tx_head ^ ParOdd;
              tx_state_d = StStart;
            end else begin
              tx_state_d = StIdle;
            end
          end else begin
            tx_tick_d = tx_tick_q + 6'd1;
          end
        end
      end
      default: tx_state_d = StIdle;
    endcase
  end

  // Transmitter state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= StIdle;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
    end
  end

  // Line level follows the current frame field; idle and stop are high
  always_comb begin
    tx = 1'b1;
    case (tx_state_q)
      StStart: tx = 1'b0;
      StData:  tx = tx_shift_q[0];
      StPar:   tx = tx_par_q;
      default: tx = 1'b1;
    endcase
  end

  assign tx_busy = (tx_state_q != StIdle) || !tx_empty;

  // --------------------------------------------------------------------------
  // Sticky error flags
  // --------------------------------------------------------------------------
  logic parity_err_q, frame_err_q, overrun_err_q;

  // Clear wins over a set in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else if (err_clr) begin
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      if (par_set)   parity_err_q  <= 1'b1;
      if (frame_set) frame_err_q   <= 1'b1;
      if (ovr_set)   overrun_err_q <= 1'b1;
    end
  end

  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule
